// File: rtl/undo_log_writer.sv
// undo_log_writer
//   Takes the undo-log entries emitted by a task core ({old data, address}),
//   buffers them in a small FIFO and writes each one to the core's private
//   undo-log region as a 2-beat AXI write burst: beat 0 carries the address,
//   beat 1 the old data. Slot n of the region lives at log_base + n*8.
//   Keeps a per-task entry count and reports when everything has drained.
//
// Ports
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   undo_log_entry[_ap_vld/_ap_rdy]  entry ingress, accepted on vld & rdy
//   log_base                  byte base of the log region (stable until drained)
//   task_begin                one-cycle pulse: restart the log for a new task
//   drained                   nothing buffered, no burst in flight, no pending clear
//   log_count                 entries written or dropped since last clear (saturating)
//   overflow, resp_err        sticky flags since last clear
//   m_axi_l1_V_*              AXI write-address, write-data and write-response channels
module undo_log_writer #(
  parameter int UNDO_LOG_ADDR_WIDTH = 32,
  parameter int UNDO_LOG_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH          = 4,
  parameter int MAX_ENTRIES         = 64
) (
  input  logic                                               ap_clk,
  input  logic                                               ap_rst_n,
  input  logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
  input  logic                                               undo_log_entry_ap_vld,
  output logic                                               undo_log_entry_ap_rdy,
  input  logic [31:0]                                        log_base,
  input  logic                                               task_begin,
  output logic                                               drained,
  output logic [7:0]                                         log_count,
  output logic                                               overflow,
  output logic                                               resp_err,
  output logic                                               m_axi_l1_V_AWVALID,
  input  logic                                               m_axi_l1_V_AWREADY,
  output logic [31:0]                                        m_axi_l1_V_AWADDR,
  output logic [7:0]                                         m_axi_l1_V_AWLEN,
  output logic [2:0]                                         m_axi_l1_V_AWSIZE,
  output logic                                               m_axi_l1_V_WVALID,
  input  logic                                               m_axi_l1_V_WREADY,
  output logic [31:0]                                        m_axi_l1_V_WDATA,
  output logic [3:0]                                         m_axi_l1_V_WSTRB,
  output logic                                               m_axi_l1_V_WLAST,
  input  logic                                               m_axi_l1_V_BVALID,
  output logic                                               m_axi_l1_V_BREADY,
  input  logic [1:0]                                         m_axi_l1_V_BRESP
);

  localparam int ENTRY_W = UNDO_LOG_ADDR_WIDTH + UNDO_LOG_DATA_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int IDX_W   = $clog2(MAX_ENTRIES) + 1;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_ENTRIES);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA0, S_DATA1, S_RESP} state_t;

  state_t state_reg, state_next;

  // Entry buffer; pointers carry one extra wrap bit to tell full from empty.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
  // Write pointer captured at task_begin: entries before it belong to the
  // old task and must be written before the clear is applied.
  logic [PTR_W:0]     clear_ptr_reg;
  logic               pending_reg;
  logic [IDX_W-1:0]   index_reg;
  logic [7:0]         log_count_reg;
  logic               overflow_reg;
  logic               resp_err_reg;

  logic fifo_empty, fifo_full, push, pop;
  logic slot_free, clear_hit, drop, done;
  logic [ENTRY_W-1:0]             head;
  logic [UNDO_LOG_ADDR_WIDTH-1:0] head_addr;
  logic [UNDO_LOG_DATA_WIDTH-1:0] head_data;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign push       = undo_log_entry_ap_vld && !fifo_full;
  assign pop        = drop || done;
  assign slot_free  = (index_reg < MAX_IDX);

  // The head is held in the FIFO until its write response arrives.
  assign head      = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign head_addr = head[UNDO_LOG_ADDR_WIDTH-1:0];
  assign head_data = head[ENTRY_W-1:UNDO_LOG_ADDR_WIDTH];

  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= undo_log_entry;
  end

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_reg <= S_IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_next = state_reg;
    clear_hit  = 1'b0;
    drop       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A deferred clear fires once every old-task entry has left; a fresh
        // task_begin with nothing buffered clears immediately.
        if (pending_reg) clear_hit = (rd_ptr_reg == clear_ptr_reg);
        else             clear_hit = task_begin && fifo_empty;
        if (!clear_hit) begin
          if (!fifo_empty) begin
            if (slot_free) state_next = S_ADDR;
            else           drop       = 1'b1;
          end else if (push && slot_free) begin
            // Start on the entry being written this cycle so the address
            // phase can begin the cycle right after the push.
            state_next = S_ADDR;
          end
        end
      end
      S_ADDR:  if (m_axi_l1_V_AWREADY) state_next = S_DATA0;
      S_DATA0: if (m_axi_l1_V_WREADY)  state_next = S_DATA1;
      S_DATA1: if (m_axi_l1_V_WREADY)  state_next = S_RESP;
      S_RESP: begin
        if (m_axi_l1_V_BVALID) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_axi_l1_V_AWVALID = 1'b0;
    m_axi_l1_V_WVALID  = 1'b0;
    m_axi_l1_V_WLAST   = 1'b0;
    m_axi_l1_V_WDATA   = 32'd0;
    m_axi_l1_V_BREADY  = 1'b0;
    case (state_reg)
      S_ADDR:  m_axi_l1_V_AWVALID = 1'b1;
      S_DATA0: begin
        m_axi_l1_V_WVALID = 1'b1;
        m_axi_l1_V_WDATA  = 32'(head_addr);
      end
      S_DATA1: begin
        m_axi_l1_V_WVALID = 1'b1;
        m_axi_l1_V_WLAST  = 1'b1;
        m_axi_l1_V_WDATA  = 32'(head_data);
      end
      S_RESP:  m_axi_l1_V_BREADY = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_l1_V_AWADDR = log_base + 32'({index_reg, 3'b000});
  assign m_axi_l1_V_AWLEN  = 8'd1;
  assign m_axi_l1_V_AWSIZE = 3'b010;
  assign m_axi_l1_V_WSTRB  = 4'hF;

  // Pointers, log index, counters and sticky flags
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      clear_ptr_reg <= '0;
      pending_reg   <= 1'b0;
      index_reg     <= '0;
      log_count_reg <= 8'd0;
      overflow_reg  <= 1'b0;
      resp_err_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      if (clear_hit) begin
        index_reg     <= '0;
        log_count_reg <= 8'd0;
        overflow_reg  <= 1'b0;
        resp_err_reg  <= 1'b0;
      end else begin
        if (done) begin
          index_reg <= index_reg + IDX_ONE;
          if (m_axi_l1_V_BRESP != 2'b00) resp_err_reg <= 1'b1;
        end
        if (drop) overflow_reg <= 1'b1;
        if (pop && (log_count_reg != 8'hFF)) log_count_reg <= log_count_reg + 8'd1;
      end

      if (clear_hit) pending_reg <= 1'b0;
      // A task_begin that cannot clear right now is remembered together with
      // the boundary between old-task and new-task entries.
      if (task_begin && !(clear_hit && fifo_empty)) begin
        pending_reg   <= 1'b1;
        clear_ptr_reg <= wr_ptr_reg;
      end
    end
  end

  assign undo_log_entry_ap_rdy = !fifo_full;
  assign drained   = fifo_empty && (state_reg == S_IDLE) && !pending_reg;
  assign log_count = log_count_reg;
  assign overflow  = overflow_reg;
  assign resp_err  = resp_err_reg;

endmodule

// File: tb/tb_undo_log_writer.sv
// Randomised self-checking bench for undo_log_writer. Stimulus pushes entries
// and task boundaries into a log-level reference model (per-task slot index,
// entry count, error flag); expected bursts go into a queue that a separate
// slave/monitor process pops as AXI handshakes occur.
module tb_undo_log_writer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [63:0] undo_log_entry;
  logic        vld, rdy;
  logic [31:0] log_base;
  logic        task_begin;
  logic        drained;
  logic [7:0]  log_count;
  logic        overflow, resp_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;

  always #5 ap_clk = ~ap_clk;

  undo_log_writer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .undo_log_entry(undo_log_entry), .undo_log_entry_ap_vld(vld), .undo_log_entry_ap_rdy(rdy),
    .log_base(log_base), .task_begin(task_begin), .drained(drained),
    .log_count(log_count), .overflow(overflow), .resp_err(resp_err),
    .m_axi_l1_V_AWVALID(awvalid), .m_axi_l1_V_AWREADY(awready), .m_axi_l1_V_AWADDR(awaddr),
    .m_axi_l1_V_AWLEN(awlen), .m_axi_l1_V_AWSIZE(awsize),
    .m_axi_l1_V_WVALID(wvalid), .m_axi_l1_V_WREADY(wready), .m_axi_l1_V_WDATA(wdata),
    .m_axi_l1_V_WSTRB(wstrb), .m_axi_l1_V_WLAST(wlast),
    .m_axi_l1_V_BVALID(bvalid), .m_axi_l1_V_BREADY(bready), .m_axi_l1_V_BRESP(bresp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] awaddr;
    logic [31:0] a;
    logic [31:0] d;
    int          tid;
  } burst_t;

  burst_t exp_q[$];
  burst_t b_q[$];
  int     m_tid = 0;
  int     m_idx = 0;
  int     m_n[128];
  bit     m_err[128];

  function automatic void model_new_task();
    if (m_tid < 127) m_tid++;
    m_idx = 0;
    m_n[m_tid] = 0;
    m_err[m_tid] = 1'b0;
  endfunction

  function automatic void model_accept(input logic [31:0] a, input logic [31:0] d);
    burst_t b;
    if (m_idx < 64) begin
      b.awaddr = log_base + 32'(m_idx * 8);
      b.a = a;
      b.d = d;
      b.tid = m_tid;
      exp_q.push_back(b);
      m_idx++;
    end
    m_n[m_tid]++;
  endfunction

  // ---------------- AXI slave + monitor ----------------
  int aw_mode = 0, w_mode = 0, b_mode = 0;   // 0 always ready, 1 random, 2 held low
  int err_mode = 0;                          // 0 OKAY, 1 random SLVERR, 2 always SLVERR
  bit mon_en = 1'b1;
  bit b_done = 1'b0;

  function automatic logic ready_for(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 1) == 1);
    return 1'b0;
  endfunction

  initial begin
    burst_t cur, bb;
    bit have_cur = 1'b0;
    int beat = 0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge ap_clk);
      awready = ready_for(aw_mode);
      wready  = ready_for(w_mode);
      if (b_done || !mon_en) begin
        bvalid = 1'b0;
        b_done = 1'b0;
      end
      if (mon_en && !bvalid && b_q.size() > 0 && (b_mode != 1 || $urandom_range(0, 2) == 0)) begin
        bvalid = 1'b1;
        if (err_mode == 2) bresp = 2'b10;
        else if (err_mode == 1 && $urandom_range(0, 9) == 0) bresp = 2'b10;
        else bresp = 2'b00;
      end
      #1;
      if (!mon_en) begin
        have_cur = 1'b0;
        continue;
      end
      if (awvalid && awready) begin
        if (exp_q.size() == 0) check_eq("aw_unexpected", 32'(awvalid), 32'd0);
        else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          beat = 0;
          check_eq("awaddr", awaddr, cur.awaddr);
          check_eq("awlen", 32'(awlen), 32'd1);
          check_eq("awsize", 32'(awsize), 32'd2);
        end
      end
      if (wvalid && wready) begin
        if (!have_cur) check_eq("w_unexpected", 32'(wvalid), 32'd0);
        else begin
          if (beat == 0) check_eq("wdata_addr", wdata, cur.a);
          else           check_eq("wdata_data", wdata, cur.d);
          check_eq("wlast", 32'(wlast), 32'(beat == 1));
          check_eq("wstrb", 32'(wstrb), 32'hF);
          beat++;
          if (beat == 2) begin
            b_q.push_back(cur);
            have_cur = 1'b0;
          end
        end
      end
      if (bvalid && bready) begin
        bb = b_q.pop_front();
        if (bresp != 2'b00) m_err[bb.tid] = 1'b1;
        b_done = 1'b1;
        $display("burst task=%0d addr=0x%08h a=0x%08h d=0x%08h bresp=%0d", bb.tid, bb.awaddr, bb.a, bb.d, bresp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_cycle();
    @(negedge ap_clk);
    vld = 1'b0;
    task_begin = 1'b0;
  endtask

  task automatic pulse_begin();
    @(negedge ap_clk);
    vld = 1'b0;
    task_begin = 1'b1;
    model_new_task();
  endtask

  task automatic push_entry(input logic [31:0] a, input logic [31:0] d, input bit with_begin);
    int guard = 0;
    @(negedge ap_clk);
    task_begin = with_begin;
    if (with_begin) model_new_task();
    vld = 1'b1;
    undo_log_entry = {d, a};
    #2;
    while (!rdy && guard < 2000) begin
      @(negedge ap_clk);
      task_begin = 1'b0;
      #2;
      guard++;
    end
    check_eq("push_accept", 32'(rdy), 32'd1);
    if (rdy) model_accept(a, d);
  endtask

  task automatic wait_drained_and_check();
    int k = 0;
    int exp_cnt;
    do begin
      @(negedge ap_clk);
      vld = 1'b0;
      task_begin = 1'b0;
      #2;
      k++;
    end while (!drained && k < 4000);
    exp_cnt = (m_n[m_tid] > 255) ? 255 : m_n[m_tid];
    check_eq("drained", 32'(drained), 32'd1);
    check_eq("log_count", 32'(log_count), 32'(exp_cnt));
    check_eq("overflow", 32'(overflow), 32'(m_n[m_tid] > 64));
    check_eq("resp_err", 32'(resp_err), 32'(m_err[m_tid]));
    check_eq("rdy_idle", 32'(rdy), 32'd1);
    check_eq("bursts_outstanding", 32'(exp_q.size() + b_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] sa [6];
    logic [31:0] sd [6];
    int acc, first, g, n;

    ap_rst_n = 1'b0; vld = 1'b0; task_begin = 1'b0;
    undo_log_entry = '0; log_base = 32'h8000;
    repeat (3) @(negedge ap_clk);
    #2;
    check_eq("rst_awvalid", 32'(awvalid), 32'd0);
    check_eq("rst_wvalid", 32'(wvalid), 32'd0);
    check_eq("rst_bready", 32'(bready), 32'd0);
    check_eq("rst_rdy", 32'(rdy), 32'd1);
    check_eq("rst_drained", 32'(drained), 32'd1);
    check_eq("rst_log_count", 32'(log_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    ap_rst_n = 1'b1;
    m_n[0] = 0; m_err[0] = 1'b0;

    // single entry, all slaves ready: address phase next cycle, drained 5 cycles after push
    push_entry(32'h0000_1040, 32'h0000_002A, 1'b0);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge ap_clk);
      vld = 1'b0;
      #2;
      if (k == 1) check_eq("awvalid_after_push", 32'(awvalid), 32'd1);
      if (drained && first == 0) first = k;
    end
    check_eq("drain_latency", 32'(first), 32'd5);
    wait_drained_and_check();

    // six back-to-back pushes with AWREADY low: only the FIFO depth is accepted
    pulse_begin();
    aw_mode = 2;
    for (int i = 0; i < 6; i++) begin
      sa[i] = $urandom;
      sd[i] = $urandom;
    end
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      task_begin = 1'b0;
      vld = 1'b1;
      undo_log_entry = {sd[acc], sa[acc]};
      #2;
      if (rdy) begin
        model_accept(sa[acc], sd[acc]);
        acc++;
      end
    end
    check_eq("accepted_while_stalled", 32'(acc), 32'd4);
    aw_mode = 0;
    for (int i = acc; i < 6; i++) push_entry(sa[i], sd[i], 1'b0);
    wait_drained_and_check();

    // task_begin with two entries queued: old entries finish first, then clear
    pulse_begin();
    aw_mode = 2;
    push_entry($urandom, $urandom, 1'b0);
    push_entry($urandom, $urandom, 1'b0);
    pulse_begin();
    aw_mode = 0;
    wait_drained_and_check();
    push_entry($urandom, $urandom, 1'b0);
    wait_drained_and_check();

    // error response: sticky until the next task_begin
    err_mode = 2;
    push_entry($urandom, $urandom, 1'b0);
    wait_drained_and_check();
    err_mode = 0;
    push_entry($urandom, $urandom, 1'b0);
    wait_drained_and_check();
    pulse_begin();
    wait_drained_and_check();

    // slot exhaustion and counter saturation under random slave timing
    aw_mode = 1; w_mode = 1; b_mode = 1;
    pulse_begin();
    for (int i = 0; i < 70; i++) push_entry($urandom, $urandom, 1'b0);
    wait_drained_and_check();
    for (int i = 0; i < 190; i++) push_entry($urandom, $urandom, 1'b0);
    wait_drained_and_check();

    // randomised tasks, including task_begin arriving with a push
    err_mode = 1;
    for (int t = 0; t < 8; t++) begin
      aw_mode = $urandom_range(0, 1);
      w_mode  = $urandom_range(0, 1);
      b_mode  = $urandom_range(0, 1);
      log_base = $urandom;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) idle_cycle();
        push_entry($urandom, $urandom, (i == 0) || ($urandom_range(0, 11) == 0));
      end
      wait_drained_and_check();
    end

    // reset asserted while the data beat with WLAST is on the bus
    err_mode = 0; aw_mode = 0; w_mode = 1; b_mode = 0;
    push_entry($urandom, $urandom, 1'b0);
    g = 0;
    do begin
      @(negedge ap_clk);
      vld = 1'b0;
      #2;
      g++;
    end while (!(wvalid && wlast) && g < 200);
    check_eq("reached_last_beat", 32'(wvalid && wlast), 32'd1);
    mon_en = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    check_eq("midrst_awvalid", 32'(awvalid), 32'd0);
    check_eq("midrst_wvalid", 32'(wvalid), 32'd0);
    check_eq("midrst_bready", 32'(bready), 32'd0);
    check_eq("midrst_drained", 32'(drained), 32'd1);
    check_eq("midrst_log_count", 32'(log_count), 32'd0);
    check_eq("midrst_rdy", 32'(rdy), 32'd1);
    exp_q.delete();
    b_q.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
